// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin pop scheduler for a bank of FIFOs.
// Each owner receives a burst of up to MAX_BURST pops. Ownership then
// rotates to the next non-empty FIFO after the previous owner.
// gnt/req/last are combinational from registered state and live inputs,
// so the selected FIFO pops on the same edge the grant is seen.
module fifo_rr_arbiter #(
    parameter int NUM_FIFOS = 4,
    parameter int TAGWIDTH  = $clog2(NUM_FIFOS),
    parameter int MAX_BURST = 4,
    parameter int CNTWIDTH  = $clog2(MAX_BURST + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_FIFOS-1:0] empty,
    input  logic                 ready,
    input  logic                 en,
    output logic [NUM_FIFOS-1:0] gnt,
    output logic                 req,
    output logic [TAGWIDTH-1:0]  gnt_sel,
    output logic                 busy,
    output logic                 last,
    output logic [CNTWIDTH-1:0]  burst_cnt
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [TAGWIDTH-1:0] owner_q, owner_d;
    logic [TAGWIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNTWIDTH-1:0] cnt_q, cnt_d;

    logic                found_s;
    logic [TAGWIDTH-1:0] winner_s;
    logic                grant_s;
    logic                last_s;
    logic [TAGWIDTH-1:0] next_ptr_s;

    // Scan rr_ptr, rr_ptr+1, ... (wrapping at NUM_FIFOS) for the first non-empty FIFO.
    always_comb begin
        found_s  = 1'b0;
        winner_s = '0;
        for (int k = 0; k < NUM_FIFOS; k++) begin
            int            idx;
            logic [TAGWIDTH-1:0] tag;
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_FIFOS) begin
                idx = idx - NUM_FIFOS;
            end else begin
                idx = idx;
            end
            tag = TAGWIDTH'(idx);
            if (!found_s && !empty[tag]) begin
                found_s  = 1'b1;
                winner_s = tag;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Grant to the owner only when enabled, downstream ready and the owner has data.
    always_comb begin
        grant_s = 1'b0;
        last_s  = 1'b0;
        gnt     = '0;
        if (state_q == ST_BURST) begin
            grant_s = en & ready & ~empty[owner_q];
        end else begin
            grant_s = 1'b0;
        end
        last_s = grant_s & (cnt_q == CNTWIDTH'(MAX_BURST - 1));
        if (grant_s) begin
            gnt = NUM_FIFOS'(1) << owner_q;
        end else begin
            gnt = '0;
        end
    end

    assign req       = |gnt;
    assign last      = last_s;
    assign gnt_sel   = owner_q;
    assign busy      = (state_q == ST_BURST);
    assign burst_cnt = cnt_q;

    // Pointer to resume scanning after the current owner; wraps without leaving 0..NUM_FIFOS-1.
    always_comb begin
        if (owner_q == TAGWIDTH'(NUM_FIFOS - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = owner_q + TAGWIDTH'(1);
        end
    end

    // Next-state logic for the IDLE/BURST scheduler.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (en && found_s) begin
                    state_d = ST_BURST;
                    owner_d = winner_s;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                // Disable or an empty owner ends the burst without a pop;
                // the final pop of a full burst ends it with one.
                if (!en || empty[owner_q] || last_s) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_ptr_s;
                    cnt_d    = '0;
                end else if (grant_s) begin
                    cnt_d = cnt_q + CNTWIDTH'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                owner_d  = '0;
                rr_ptr_d = '0;
                cnt_d    = '0;
            end
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter: FIFO occupancy is modelled by counters
// that drop on each granted edge; expected values are hand-derived per step.
module tb_fifo_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] empty;
    logic       ready;
    logic       en;
    logic [3:0] gnt;
    logic       req;
    logic [1:0] gnt_sel;
    logic       busy;
    logic       last;
    logic [2:0] burst_cnt;

    int fcnt [4];
    int checks;
    int errors;
    int pops;

    fifo_rr_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .empty     (empty),
        .ready     (ready),
        .en        (en),
        .gnt       (gnt),
        .req       (req),
        .gnt_sel   (gnt_sel),
        .busy      (busy),
        .last      (last),
        .burst_cnt (burst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Empty flags follow the modelled occupancy.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            empty[i] = (fcnt[i] == 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle: pop whatever is granted at the edge, return at the next negedge.
    task automatic tick();
        logic [3:0] g;
        g = gnt;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) begin
                fcnt[i] = fcnt[i] - 1;
                pops++;
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic set_fifos(input int a, input int b, input int c, input int d);
        fcnt[0] = a;
        fcnt[1] = b;
        fcnt[2] = c;
        fcnt[3] = d;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    logic       exp_last;
    logic [3:0] exp_gnt;
    logic [6:0] bp_ready;
    logic [3:0] bp_gnt [7];
    logic [2:0] bp_cnt [7];

    initial begin
        checks = 0;
        errors = 0;
        pops   = 0;
        rst    = 1'b1;
        en     = 1'b1;
        ready  = 1'b1;
        set_fifos(5, 5, 5, 5);
        @(negedge clk);
        #1;

        // 1. Reset holds everything quiet even with demand present.
        for (int r = 0; r < 2; r++) begin
            chk("rst_gnt", 32'(gnt), 32'd0);
            chk("rst_req", 32'(req), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_sel", 32'(gnt_sel), 32'd0);
            chk("rst_cnt", 32'(burst_cnt), 32'd0);
            chk("rst_last", 32'(last), 32'd0);
            tick();
        end

        // 2. Single FIFO 2 with 6 entries.
        set_fifos(0, 0, 6, 0);
        pops = 0;
        rst  = 1'b0;
        #1;
        chk("s2_c0_gnt", 32'(gnt), 32'd0);
        chk("s2_c0_busy", 32'(busy), 32'd0);
        tick();
        for (int c = 1; c <= 4; c++) begin
            exp_last = (c == 4);
            chk("s2_gnt", 32'(gnt), 32'h4);
            chk("s2_sel", 32'(gnt_sel), 32'd2);
            chk("s2_cnt", 32'(burst_cnt), 32'(c - 1));
            chk("s2_last", 32'(last), 32'(exp_last));
            tick();
        end
        chk("s2_c5_busy", 32'(busy), 32'd0);
        chk("s2_c5_gnt", 32'(gnt), 32'd0);
        tick();
        chk("s2_c6_gnt", 32'(gnt), 32'h4);
        chk("s2_c6_cnt", 32'(burst_cnt), 32'd0);
        tick();
        chk("s2_c7_gnt", 32'(gnt), 32'h4);
        chk("s2_c7_cnt", 32'(burst_cnt), 32'd1);
        tick();
        chk("s2_c8_busy", 32'(busy), 32'd1);
        chk("s2_c8_gnt", 32'(gnt), 32'd0);
        tick();
        chk("s2_c9_busy", 32'(busy), 32'd0);
        chk("s2_pops", 32'(pops), 32'd6);
        // rr_ptr is now 3: with every FIFO non-empty, FIFO 3 wins next.
        set_fifos(20, 20, 20, 20);
        tick();
        chk("s2_rrptr_sel", 32'(gnt_sel), 32'd3);
        chk("s2_rrptr_gnt", 32'(gnt), 32'h8);

        // 3. All FIFOs deep: owners 0,1,2,3,0 with 4 grants and one idle cycle each.
        do_reset();
        set_fifos(20, 20, 20, 20);
        for (int b = 0; b < 5; b++) begin
            for (int c = 0; c < 5; c++) begin
                if (c == 0) begin
                    exp_gnt = 4'b0000;
                end else begin
                    exp_gnt = 4'b0001 << (b % 4);
                end
                exp_last = (c == 4);
                chk("s3_gnt", 32'(gnt), 32'(exp_gnt));
                chk("s3_last", 32'(last), 32'(exp_last));
                chk("s3_onehot", 32'($countones(gnt) <= 1), 32'd1);
                tick();
            end
        end

        // 4. Backpressure on FIFO 1.
        do_reset();
        set_fifos(0, 10, 0, 0);
        bp_ready = 7'b1011001;   // bit k is ready in burst cycle k: 1,0,0,1,1,0,1
        bp_gnt[0] = 4'h2; bp_gnt[1] = 4'h0; bp_gnt[2] = 4'h0; bp_gnt[3] = 4'h2;
        bp_gnt[4] = 4'h2; bp_gnt[5] = 4'h0; bp_gnt[6] = 4'h2;
        bp_cnt[0] = 3'd0; bp_cnt[1] = 3'd1; bp_cnt[2] = 3'd1; bp_cnt[3] = 3'd1;
        bp_cnt[4] = 3'd2; bp_cnt[5] = 3'd3; bp_cnt[6] = 3'd3;
        chk("s4_idle_gnt", 32'(gnt), 32'd0);
        tick();
        for (int k = 0; k < 7; k++) begin
            ready = bp_ready[k];
            #1;
            exp_last = (k == 6);
            chk("s4_gnt", 32'(gnt), 32'(bp_gnt[k]));
            chk("s4_cnt", 32'(burst_cnt), 32'(bp_cnt[k]));
            chk("s4_busy", 32'(busy), 32'd1);
            chk("s4_last", 32'(last), 32'(exp_last));
            tick();
        end
        ready = 1'b1;
        #1;
        chk("s4_end_busy", 32'(busy), 32'd0);

        // 5. Wrap priority.
        do_reset();
        set_fifos(0, 0, 0, 1);
        chk("s5_c0_gnt", 32'(gnt), 32'd0);
        tick();
        chk("s5_own3_gnt", 32'(gnt), 32'h8);
        tick();
        chk("s5_own3_exit_gnt", 32'(gnt), 32'd0);
        chk("s5_own3_exit_busy", 32'(busy), 32'd1);
        tick();
        set_fifos(5, 0, 0, 5);
        chk("s5_idle_busy", 32'(busy), 32'd0);
        tick();
        chk("s5_wrap_sel", 32'(gnt_sel), 32'd0);
        chk("s5_wrap_gnt", 32'(gnt), 32'h1);
        tick();
        en = 1'b0;
        #1;
        chk("s5_en_low_gnt", 32'(gnt), 32'd0);
        chk("s5_en_low_busy", 32'(busy), 32'd1);
        tick();
        en = 1'b1;
        set_fifos(0, 1, 0, 0);
        chk("s5_idle2_busy", 32'(busy), 32'd0);
        tick();
        chk("s5_own1_gnt", 32'(gnt), 32'h2);
        tick();
        chk("s5_own1_exit_gnt", 32'(gnt), 32'd0);
        tick();
        set_fifos(5, 0, 0, 5);
        chk("s5_idle3_busy", 32'(busy), 32'd0);
        tick();
        chk("s5_next3_sel", 32'(gnt_sel), 32'd3);
        chk("s5_next3_gnt", 32'(gnt), 32'h8);

        // 6. Asynchronous reset in the middle of a burst.
        do_reset();
        set_fifos(0, 0, 8, 0);
        tick();
        tick();
        tick();
        chk("s6_pre_gnt", 32'(gnt), 32'h4);
        chk("s6_pre_cnt", 32'(burst_cnt), 32'd2);
        #1;
        rst = 1'b1;
        #1;
        chk("s6_async_gnt", 32'(gnt), 32'd0);
        chk("s6_async_busy", 32'(busy), 32'd0);
        chk("s6_async_cnt", 32'(burst_cnt), 32'd0);
        chk("s6_async_sel", 32'(gnt_sel), 32'd0);
        set_fifos(0, 5, 5, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("s6_idle_gnt", 32'(gnt), 32'd0);
        tick();
        chk("s6_next_sel", 32'(gnt_sel), 32'd1);
        chk("s6_next_gnt", 32'(gnt), 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
